// File: rtl/cipher_frame_rx.sv
// cipher_frame_rx: serial cipher-frame receiver producing a one-hot decrypted nibble
module cipher_frame_rx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic [3:0]  public_key,
    output logic [15:0] hexadecimal_output,
    output logic        out_valid,
    output logic        frame_err,
    output logic        key_err,
    output logic        busy
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sr;
    logic par, tick, par_err;
    logic [3:0] x, b, n, f;
    logic [2:0] ones;
    logic [15:0] result;
    always_comb begin
        x = sr[3:0] ^ sr[7:4] ^ public_key;
        b = {x[3], ^x[3:2], ^x[3:1], ^x};
        n = ~b;
        result = 16'h1 << n;
        ones = 3'($countones(x));
        f = {ones >= 3'd4, ones >= 3'd3, ones >= 3'd2, ones >= 3'd1};
        par_err = ^{sr, par};
        tick = (state == START) ? (cnt == HALF) : (cnt == LAST);
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            sr <= '0;
            par <= 1'b0;
            hexadecimal_output <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            key_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            key_err <= 1'b0;
            cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (!rx_in) state <= START;
                START: if (tick) begin
                    state <= rx_in ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    sr <= {rx_in, sr[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: if (tick) begin
                    par <= rx_in;
                    state <= STOP;
                end
                STOP: if (tick) begin
                    if (par_err || !rx_in) begin
                        frame_err <= 1'b1;
                        state <= rx_in ? IDLE : WAIT_IDLE;
                    end else if (f != sr[7:4]) begin
                        key_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hexadecimal_output <= result;
                        out_valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                WAIT_IDLE: if (rx_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_frame_rx.sv
// tb_cipher_frame_rx: randomized self-checking bench against an arithmetic frame model
module tb_cipher_frame_rx;
    localparam int BC = 4;
    localparam int H = BC / 2;
    localparam int SE = H + 10 * BC;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_in = 1'b1;
    logic [3:0] public_key = 4'h0;
    logic [15:0] hexadecimal_output;
    logic out_valid, frame_err, key_err, busy;
    int checks = 0;
    int errors = 0;
    logic [15:0] last_hex = 16'h0000;
    cipher_frame_rx #(.BIT_CYCLES(BC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_in(rx_in),
        .public_key(public_key),
        .hexadecimal_output(hexadecimal_output),
        .out_valid(out_valid),
        .frame_err(frame_err),
        .key_err(key_err),
        .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] model_hex(input logic [3:0] e, k, pk);
        logic [3:0] x, bv;
        logic acc;
        x = e ^ k ^ pk;
        acc = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            acc = acc ^ x[i];
            bv[i] = acc;
        end
        return 16'(1) << (15 - int'(bv));
    endfunction
    function automatic logic key_ok(input logic [3:0] e, k, pk);
        logic [3:0] fx;
        int c;
        c = $countones(e ^ k ^ pk);
        for (int j = 0; j < 4; j++) fx[j] = c > j;
        return fx == k;
    endfunction
    function automatic int model_kind(input logic [3:0] e, k, pk, input logic p, s);
        if (($countones({e, k, p}) % 2) != 0 || !s) return 2;
        if (!key_ok(e, k, pk)) return 3;
        return 1;
    endfunction
    function automatic logic [3:0] pick_key(input logic [3:0] e, pk);
        for (int k = 0; k < 16; k++) if (key_ok(e, 4'(k), pk)) return 4'(k);
        return 4'($urandom);
    endfunction
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk) rx_in = 1'b1;
            @(posedge clk);
        end
    endtask
    task automatic run_frame(input logic [3:0] e, k, pk, input logic p, s, input int len, input string name);
        logic [10:0] bits;
        int nv, nf, nk, at, kind;
        logic mutex_bad, busy_ok;
        bits = {s, p, k, e, 1'b0};
        kind = model_kind(e, k, pk, p, s);
        if (kind == 1) last_hex = model_hex(e, k, pk);
        nv = 0; nf = 0; nk = 0; at = -1; mutex_bad = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_in = bits[i / BC];
            public_key = (i == SE) ? pk : 4'($urandom);
            @(posedge clk);
            #1;
            if (out_valid) begin nv++; at = i + 1; end
            if (frame_err) begin nf++; at = i + 1; end
            if (key_err) begin nk++; at = i + 1; end
            if (int'(out_valid) + int'(frame_err) + int'(key_err) > 1) mutex_bad = 1'b1;
        end
        checks++;
        if (nv != (kind == 1 ? 1 : 0) || nf != (kind == 2 ? 1 : 0) || nk != (kind == 3 ? 1 : 0)) begin
            errors++;
            $display("FAIL %s pulses: got v=%0d f=%0d k=%0d, want kind %0d", name, nv, nf, nk, kind);
        end
        checks++;
        if (at != SE + 1) begin
            errors++;
            $display("FAIL %s pulse_cycle: got c0+%0d, want c0+%0d", name, at, SE + 1);
        end
        checks++;
        if (hexadecimal_output !== last_hex) begin
            errors++;
            $display("FAIL %s hex: got %h, want %h", name, hexadecimal_output, last_hex);
        end
        checks++;
        if (mutex_bad) begin
            errors++;
            $display("FAIL %s mutex: got overlapping pulses, want at most one", name);
        end
        if (!s) begin
            busy_ok = 1'b1;
            repeat (20) begin
                @(negedge clk) rx_in = 1'b0;
                @(posedge clk);
                #1;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            checks++;
            if (!busy_ok) begin
                errors++;
                $display("FAIL %s wait_busy: got busy low while line low, want 1", name);
            end
            @(negedge clk) rx_in = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s wait_release: got busy %b, want 0", name, busy);
            end
        end
    endtask
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hexadecimal_output, out_valid, frame_err, key_err, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset: got hex=%h v=%b f=%b k=%b busy=%b, want all 0",
                     hexadecimal_output, out_valid, frame_err, key_err, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        idle(2);
    endtask
    task automatic test_scenarios;
        run_frame(4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b1, 11 * BC, "sc1");
        checks++;
        if (hexadecimal_output !== 16'h0020) begin
            errors++;
            $display("FAIL sc1_value: got %h, want 0020", hexadecimal_output);
        end
        idle(3);
        run_frame(4'b0011, 4'b0001, 4'b1010, 1'b1, 1'b1, 11 * BC, "sc2");
        checks++;
        if (hexadecimal_output !== 16'h0001) begin
            errors++;
            $display("FAIL sc2_value: got %h, want 0001", hexadecimal_output);
        end
        idle(3);
        run_frame(4'b0011, 4'b1111, 4'b0011, 1'b1, 1'b1, 11 * BC, "sc3_parity");
        idle(3);
        run_frame(4'b0011, 4'b1110, 4'b0011, 1'b1, 1'b1, 11 * BC, "sc5_key");
        idle(3);
        run_frame(4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b0, 11 * BC, "sc4_stop");
        idle(3);
    endtask
    task automatic test_glitch;
        int pulses;
        logic late_busy, early_busy;
        pulses = 0; late_busy = 1'b0; early_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) rx_in = (i != 0);
            @(posedge clk);
            #1;
            pulses += int'(out_valid) + int'(frame_err) + int'(key_err);
            if (i == 0) early_busy = busy;
            if (i >= H && busy) late_busy = 1'b1;
        end
        checks++;
        if (!early_busy || late_busy || pulses != 0) begin
            errors++;
            $display("FAIL glitch: got start_busy=%b late_busy=%b pulses=%0d, want 1 0 0",
                     early_busy, late_busy, pulses);
        end
        checks++;
        if (hexadecimal_output !== last_hex) begin
            errors++;
            $display("FAIL glitch_hex: got %h, want %h", hexadecimal_output, last_hex);
        end
    endtask
    task automatic test_reset_mid;
        logic [10:0] bits;
        bits = {1'b1, 1'b0, 4'b1111, 4'b0011, 1'b0};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk) rx_in = bits[i / BC];
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        checks++;
        if ({hexadecimal_output, out_valid, frame_err, key_err, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid: got hex=%h v=%b f=%b k=%b busy=%b, want all 0",
                     hexadecimal_output, out_valid, frame_err, key_err, busy);
        end
        last_hex = 16'h0000;
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b, want 0", busy);
        end
        run_frame(4'b0011, 4'b1111, 4'b0011, 1'b0, 1'b1, 11 * BC, "after_reset");
        idle(2);
    endtask
    task automatic test_random;
        logic [3:0] e, k, pk;
        logic p, s;
        for (int t = 0; t < 40; t++) begin
            e = 4'($urandom);
            pk = 4'($urandom);
            k = ($urandom_range(1) == 1) ? pick_key(e, pk) : 4'($urandom);
            p = 1'($countones({e, k}) % 2);
            if ($urandom_range(4) == 0) p = ~p;
            s = $urandom_range(9) != 0;
            run_frame(e, k, pk, p, s, 11 * BC, "random");
            idle($urandom_range(3));
        end
    endtask
    task automatic test_back_to_back;
        logic [3:0] e, k, pk;
        for (int t = 0; t < 6; t++) begin
            e = 4'($urandom);
            pk = 4'($urandom);
            k = pick_key(e, pk);
            run_frame(e, k, pk, 1'($countones({e, k}) % 2), 1'b1, SE + 1, "back_to_back");
        end
        idle(3);
    endtask
    initial begin
        test_reset;
        test_scenarios;
        test_glitch;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cipher_frame_rx.md
CIPHER_FRAME_RX -- requirements
Module: cipher_frame_rx

Interface
REQ-001 Parameter BIT_CYCLES, default 4, clocks per serial bit; legal values are even and >= 2.
REQ-002 Port clk, input, 1, the only clock; all flops are rising-edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port rx_in, input, 1, serial line; synchronous to clk; idle high.
REQ-005 Port public_key, input, 4, public key; sampled at the stop-bit sample.
REQ-006 Port hexadecimal_output, output, 16, one-hot decrypted value; registered.
REQ-007 Port out_valid, output, 1, one-cycle pulse marking a new hexadecimal_output.
REQ-008 Port frame_err, output, 1, one-cycle pulse on a parity or stop error.
REQ-009 Port key_err, output, 1, one-cycle pulse when the received private key is inconsistent.
REQ-010 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 Frame format SHALL be 11 bits:
- start bit (0)
- encrypted nibble E[3:0], LSB first
- private key K[3:0], LSB first
- even parity over E and K (count of ones over the 9 bits is even)
- stop bit (1)
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-013 In IDLE, the first cycle with rx_in=0 is cycle c0. The block SHALL move to START and clear the bit counter.
REQ-014 Sample points SHALL fall at c0 + BIT_CYCLES/2 + k*BIT_CYCLES, for k = 0..10.
REQ-015 At k=0, if rx_in=1 the block SHALL return to IDLE silently (glitch), with no pulse.
REQ-016 Samples k=1..8 SHALL shift into an 8-bit register. E occupies bits [3:0] and K occupies bits [7:4].
REQ-017 Decryption SHALL be combinational from E, K and public_key, and registered only at the stop sample:
- X = E ^ K ^ public_key
- B = gray-to-binary(X): B3=X3, Bi=B(i+1)^Xi
- N = ~B
- result = 16'h1 << N
REQ-018 The key check SHALL compute F(X) and compare it with K, where F(X) is:
- F[3] = all four bits of X set
- F[2] = at least 3 bits set
- F[1] = at least 2 bits set
- F[0] = at least 1 bit set
REQ-019 At the stop sample (k=10), the block SHALL evaluate the following in priority order:
- Parity error, or rx_in=0: frame_err pulse; go to WAIT_IDLE if rx_in=0, else to IDLE.
- Else, F(X) != K: key_err pulse; go to IDLE.
- Else: hexadecimal_output <= result and out_valid pulse, both in cycle c0 + BIT_CYCLES/2 + 10*BIT_CYCLES + 1; go to IDLE.
REQ-020 WAIT_IDLE SHALL stay until rx_in=1 is sampled on any clock, then go to IDLE.
REQ-021 hexadecimal_output SHALL hold its last value on any error or glitch.
REQ-022 At most one of out_valid, frame_err and key_err SHALL be high in any cycle.
REQ-023 A new start bit SHALL be accepted in the cycle immediately after a return to IDLE, so back-to-back frames have no gap.
REQ-024 The BIT_CYCLES counter SHALL wrap at BIT_CYCLES-1 and never exceed that value.
REQ-025 public_key changes outside the stop sample SHALL NOT affect the result.

Reset
REQ-026 While rst_n=0, the block SHALL be held as follows:
- state IDLE
- counters and shift register at 0
- hexadecimal_output = 16'h0000
- out_valid, frame_err, key_err, busy all 0
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no pulse. After release, decoding SHALL restart only on a fresh falling edge.

Verification
REQ-028 Scenario 1 (valid frame): public_key=4'b0011, line 0,1100,1111,0,1 (E=0011, K=1111) -> hexadecimal_output=16'h0020 and out_valid for 1 cycle at c0+43.
REQ-029 Scenario 2 (valid frame): public_key=4'b1010, line 0,1100,1000,1,1 (E=0011, K=0001) -> hexadecimal_output=16'h0001 and out_valid pulse.
REQ-030 Scenario 3 (parity error): scenario 1 with the parity bit set to 1 -> frame_err pulse, no out_valid, hexadecimal_output unchanged.
REQ-031 Scenario 4 (stop error): scenario 1 with stop=0 and the line held low for 20 cycles -> frame_err pulse, busy high until rx_in returns high, then IDLE.
REQ-032 Scenario 5 (key error): scenario 1 with K=1110 and parity adjusted to 1 -> key_err pulse, no out_valid.
REQ-033 Scenario 6 (glitch and reset): a 1-cycle low glitch -> no pulse and busy low by c0+3; rst_n low during the DATA state -> all outputs 0 at once, and a following scenario 1 frame decodes correctly.
